// File: rtl/llc_set_buf_fill_pkg.sv
// Shared LLC set-buffer types: set/way/tag/state widths, state encodings
// and the fill FSM state enum.
package llc_set_buf_fill_pkg;
  localparam int LLC_WAYS  = 16;
  localparam int LLC_SET_W = 10;
  localparam int LLC_TAG_W = 20;

  typedef logic [LLC_SET_W-1:0]        llc_set_t;
  typedef logic [$clog2(LLC_WAYS)-1:0] llc_way_t;
  typedef logic [LLC_TAG_W-1:0]        llc_tag_t;
  typedef logic [1:0]                  llc_state_t;

  localparam llc_state_t LLC_ST_INVALID = 2'd0;
  localparam llc_state_t LLC_ST_VALID   = 2'd1;
  localparam llc_state_t LLC_ST_SHARED  = 2'd2;
  localparam llc_state_t LLC_ST_DIRTY   = 2'd3;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_READ  = 2'd1,
    FILL_DRAIN = 2'd2,
    FILL_DONE  = 2'd3
  } llc_set_buf_fill_state_t;
endpackage

// File: rtl/llc_set_buf_fill_if.sv
// Set-request handshake plus tag/state and eviction-pointer memory read bus.
// slave = the fill block, master = front-end / memory side.
interface llc_set_buf_fill_if;
  import llc_set_buf_fill_pkg::*;

  logic       set_valid;
  logic       set_ready;
  llc_set_t   set_in;
  logic       mem_rd_en;
  llc_set_t   mem_rd_set;
  llc_way_t   mem_rd_way;
  llc_tag_t   mem_rd_tag;
  llc_state_t mem_rd_state;
  logic       evict_rd_en;
  llc_way_t   evict_rd_data;

  modport slave (
    input  set_valid, set_in, mem_rd_tag, mem_rd_state, evict_rd_data,
    output set_ready, mem_rd_en, mem_rd_set, mem_rd_way, evict_rd_en
  );

  modport master (
    output set_valid, set_in, mem_rd_tag, mem_rd_state, evict_rd_data,
    input  set_ready, mem_rd_en, mem_rd_set, mem_rd_way, evict_rd_en
  );
endinterface

// File: rtl/llc_rd_delay.sv
// RD_LATENCY-deep shift register of {valid, way}, aligning each read issue
// with its returning memory data. Async active-low clear drops in-flight reads.
module llc_rd_delay #(
  parameter int RD_LATENCY = 1,
  parameter int WW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [WW-1:0] i_way,
  output logic          o_vld,
  output logic [WW-1:0] o_way
);
  logic [RD_LATENCY:1]         vld_pipe;
  logic [RD_LATENCY:1][WW-1:0] way_pipe;

  // shift issue tags one stage per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      way_pipe <= '0;
    end else begin
      vld_pipe[1] <= i_vld;
      way_pipe[1] <= i_way;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        way_pipe[s] <= way_pipe[s-1];
      end
    end
  end

  assign o_vld = vld_pipe[RD_LATENCY];
  assign o_way = way_pipe[RD_LATENCY];
endmodule

// File: rtl/llc_set_buf_fill.sv
// Per-set tag/state/evict-pointer buffer fill for the LLC way-lookup stage.
// Reads every way of an accepted set (one per cycle) plus the eviction
// pointer, buffers the results and pulses lookup_en when complete.
// Optional: LLC_SET_BUF_BYPASS_EN re-serves a still-valid buffer for a
// repeated set without touching memory.
module llc_set_buf_fill
  import llc_set_buf_fill_pkg::*;
#(
  parameter int WAYS       = LLC_WAYS,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  llc_set_buf_fill_if.slave           bus,
  input  logic                        upd_en,
  input  llc_way_t                    upd_way,
  input  llc_tag_t                    upd_tag,
  input  llc_state_t                  upd_state,
  input  logic                        evict_upd_en,
  input  llc_way_t                    evict_upd_val,
  output llc_tag_t   [WAYS-1:0]       tags_buf,
  output llc_state_t [WAYS-1:0]       states_buf,
  output llc_way_t                    evict_ways_buf,
  output llc_set_t                    buf_set,
  output logic                        buf_valid,
  output logic                        lookup_en
);
  localparam int             WW         = $clog2(WAYS);
  localparam logic [WW-1:0]  LAST_WAY   = WW'(WAYS - 1);
  localparam logic [2:0]     DRAIN_INIT = 3'(RD_LATENCY - 1);

  llc_set_buf_fill_state_t r_state;
  logic [WW-1:0]           r_cnt;
  logic [2:0]              r_drain;
  llc_set_t                r_buf_set;
  logic                    r_buf_valid;
  llc_tag_t   [WAYS-1:0]   r_tags;
  llc_state_t [WAYS-1:0]   r_states;
  llc_way_t                r_evict;
  logic       [WAYS-1:0]   r_mask;
  logic                    r_evict_upd;

  logic          w_accept, w_hit, w_fill_start, w_rd_en;
  logic          w_upd_live, w_upd, w_eupd;
  logic          w_cap_vld;
  logic [WW-1:0] w_cap_way, w_upd_idx;

  assign w_accept = (r_state == FILL_IDLE) && bus.set_valid;
`ifdef LLC_SET_BUF_BYPASS_EN
  assign w_hit = r_buf_valid && (bus.set_in == r_buf_set);
`else
  assign w_hit = 1'b0;
`endif
  assign w_fill_start = w_accept && !w_hit;
  assign w_rd_en      = (r_state == FILL_READ);

  // Updates belong to the set held (or being loaded); an empty idle buffer ignores them.
  assign w_upd_live = (r_state != FILL_IDLE) || r_buf_valid;
  assign w_upd      = upd_en && w_upd_live;
  assign w_eupd     = evict_upd_en && w_upd_live;
  assign w_upd_idx  = upd_way[WW-1:0];

  llc_rd_delay #(.RD_LATENCY(RD_LATENCY), .WW(WW)) u_rd_delay (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_rd_en),
    .i_way (r_cnt),
    .o_vld (w_cap_vld),
    .o_way (w_cap_way)
  );

  // Fill FSM: accept, issue one way per cycle, drain the read latency, announce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL_IDLE;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_buf_set   <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          if (w_accept) begin
            r_buf_set <= bus.set_in;
            if (w_hit) begin
              r_state <= FILL_DONE;
            end else begin
              r_state     <= FILL_READ;
              r_cnt       <= '0;
              r_buf_valid <= 1'b0;
            end
          end
        end
        FILL_READ: begin
          // counter wraps to 0 after the last way; that wrap value is never issued
          r_cnt <= r_cnt + WW'(1);
          if (r_cnt == LAST_WAY) begin
            r_state <= FILL_DRAIN;
            r_drain <= DRAIN_INIT;
          end
        end
        FILL_DRAIN: begin
          if (r_drain == 3'd0) r_state <= FILL_DONE;
          else                 r_drain <= r_drain - 3'd1;
        end
        FILL_DONE: begin
          r_buf_valid <= 1'b1;
          r_state     <= FILL_IDLE;
        end
        default: r_state <= FILL_IDLE;
      endcase
    end
  end

  // Buffer capture; downstream updates are written last so they win over
  // a same-cycle capture, and the mask blocks later captures of that way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tags      <= '0;
      r_states    <= '0;
      r_evict     <= '0;
      r_mask      <= '0;
      r_evict_upd <= 1'b0;
    end else begin
      if (w_fill_start) begin
        r_mask      <= '0;
        r_evict_upd <= 1'b0;
      end
      if (w_cap_vld && !r_mask[w_cap_way]) begin
        r_tags[w_cap_way]   <= bus.mem_rd_tag;
        r_states[w_cap_way] <= bus.mem_rd_state;
      end
      // way 0 is the first issue, the same cycle the pointer read went out
      if (w_cap_vld && (w_cap_way == '0) && !r_evict_upd)
        r_evict <= bus.evict_rd_data;
      if (w_upd) begin
        r_tags[w_upd_idx]   <= upd_tag;
        r_states[w_upd_idx] <= upd_state;
        if (!w_fill_start) r_mask[w_upd_idx] <= 1'b1;
      end
      if (w_eupd) begin
        r_evict <= evict_upd_val;
        if (!w_fill_start) r_evict_upd <= 1'b1;
      end
    end
  end

  // Strobes and status decode straight from the state register
  assign bus.set_ready   = (r_state == FILL_IDLE);
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_set  = r_buf_set;
  assign bus.mem_rd_way  = llc_way_t'(r_cnt);
  assign bus.evict_rd_en = w_rd_en && (r_cnt == '0);
  assign lookup_en       = (r_state == FILL_DONE);

  assign tags_buf       = r_tags;
  assign states_buf     = r_states;
  assign evict_ways_buf = r_evict;
  assign buf_set        = r_buf_set;
  assign buf_valid      = r_buf_valid;
endmodule
